// File: rtl/wb_reg_file_pkg.sv
// Shared types and constants for the integer register file and its neighbours
// (pipeline registers, forwarding unit).
package wb_reg_file_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREG   = 1 << REG_AW;

    localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xlen_t;

    // A writeback only commits when it targets a real register.
    function automatic logic wb_commits(input logic en, input reg_addr_t addr);
        return en && (addr != ZERO_REG);
    endfunction

endpackage

// File: rtl/wb_rf_read_port.sv
// One register-file read port: x0 forced to zero, optional same-cycle WB write-through
// (REGFILE_WB_BYPASS_EN). Fully combinational; bypass is suppressed while rst_i is high.
module wb_rf_read_port
    import wb_reg_file_pkg::*;
#(
    parameter int unsigned XLEN = wb_reg_file_pkg::XLEN,
    parameter int unsigned AW   = wb_reg_file_pkg::REG_AW
) (
    input  logic            rst_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [XLEN-1:0] stored_i,
    input  logic            wb_en_i,
    input  logic [AW-1:0]   wb_addr_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic [XLEN-1:0] data_o
);

    logic addr_is_zero;
    assign addr_is_zero = (addr_i == '0);

`ifdef REGFILE_WB_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit = !rst_i && wb_en_i && (wb_addr_i != '0) && (wb_addr_i == addr_i);

    always_comb begin
        data_o = stored_i;
        if (addr_is_zero) begin
            data_o = '0;
        end else if (bypass_hit) begin
            data_o = wb_data_i;
        end
    end
`else
    // Without write-through the WB write port is not consulted here.
    logic unused_wb;
    assign unused_wb = ^{rst_i, wb_en_i, wb_addr_i, wb_data_i};

    always_comb begin
        data_o = stored_i;
        if (addr_is_zero) begin
            data_o = '0;
        end
    end
`endif

endmodule

// File: rtl/wb_reg_file.sv
// Architectural integer register file: one WB write port, two ID read ports, one debug port.
// Optional WB-to-ID write-through bypass enabled by defining REGFILE_WB_BYPASS_EN.
module wb_reg_file
    import wb_reg_file_pkg::*;
#(
    parameter int unsigned XLEN = wb_reg_file_pkg::XLEN,
    parameter int unsigned NREG = wb_reg_file_pkg::NREG,
    parameter int unsigned AW   = wb_reg_file_pkg::REG_AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_en_wb,
    input  logic [AW-1:0]   rd_addr_wb,
    input  logic [XLEN-1:0] rd_data_wb,
    input  logic [AW-1:0]   rs1_addr_id,
    input  logic [AW-1:0]   rs2_addr_id,
    output logic [XLEN-1:0] rs1_data_id,
    output logic [XLEN-1:0] rs2_data_id,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data,
    output logic [31:0]     wr_count
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [31:0]     wr_count_q;
    logic [31:0]     wr_count_d;
    logic            wr_commit;

    assign wr_commit = wb_en_wb && (rd_addr_wb != '0);

    always_comb begin
        wr_count_d = wr_count_q;
        if (wr_commit) begin
            wr_count_d = wr_count_q + 32'd1;
        end
    end

    // Reset wins over a same-cycle write; entry 0 is never loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
            wr_count_q <= '0;
        end else begin
            if (wr_commit) begin
                regs_q[rd_addr_wb] <= rd_data_wb;
            end
            wr_count_q <= wr_count_d;
        end
    end

    logic [XLEN-1:0] rs1_stored;
    logic [XLEN-1:0] rs2_stored;
    assign rs1_stored = regs_q[rs1_addr_id];
    assign rs2_stored = regs_q[rs2_addr_id];

    wb_rf_read_port #(.XLEN(XLEN), .AW(AW)) u_rs1_port (
        .rst_i     (rst),
        .addr_i    (rs1_addr_id),
        .stored_i  (rs1_stored),
        .wb_en_i   (wb_en_wb),
        .wb_addr_i (rd_addr_wb),
        .wb_data_i (rd_data_wb),
        .data_o    (rs1_data_id)
    );

    wb_rf_read_port #(.XLEN(XLEN), .AW(AW)) u_rs2_port (
        .rst_i     (rst),
        .addr_i    (rs2_addr_id),
        .stored_i  (rs2_stored),
        .wb_en_i   (wb_en_wb),
        .wb_addr_i (rd_addr_wb),
        .wb_data_i (rd_data_wb),
        .data_o    (rs2_data_id)
    );

    // Debug view always shows committed state, never the in-flight write.
    assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_wb_reg_file.sv
// Self-checking bench for wb_reg_file; expectations are queued at stimulus time and
// popped when the combinational outputs are sampled.
module tb_wb_reg_file;

    logic        clk;
    logic        rst;
    logic        wb_en_wb;
    logic [4:0]  rd_addr_wb;
    logic [31:0] rd_data_wb;
    logic [4:0]  rs1_addr_id;
    logic [4:0]  rs2_addr_id;
    logic [31:0] rs1_data_id;
    logic [31:0] rs2_data_id;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [31:0] wr_count;

    int          n_cmp;
    int          n_err;
    logic [31:0] exp_q [$];
    logic [31:0] exp;
    logic [31:0] model [32];
    logic [31:0] cnt_model;

`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    wb_reg_file dut (
        .clk         (clk),
        .rst         (rst),
        .wb_en_wb    (wb_en_wb),
        .rd_addr_wb  (rd_addr_wb),
        .rd_data_wb  (rd_data_wb),
        .rs1_addr_id (rs1_addr_id),
        .rs2_addr_id (rs2_addr_id),
        .rs1_data_id (rs1_data_id),
        .rs2_data_id (rs2_data_id),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .wr_count    (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i < 32; i++) begin
            rs1_addr_id = 5'(i);
            rs2_addr_id = 5'(32 - i);
            dbg_addr    = 5'(i);
            exp_q.push_back(32'h0);
            exp_q.push_back(32'h0);
            exp_q.push_back(32'h0);
            #1;
            exp = exp_q.pop_front();
            n_cmp++; if (rs1_data_id !== exp) begin n_err++; $display("FAIL reset_rs1 x%0d: got %h expected %h", i, rs1_data_id, exp); end
            exp = exp_q.pop_front();
            n_cmp++; if (rs2_data_id !== exp) begin n_err++; $display("FAIL reset_rs2 x%0d: got %h expected %h", 32 - i, rs2_data_id, exp); end
            exp = exp_q.pop_front();
            n_cmp++; if (dbg_data !== exp) begin n_err++; $display("FAIL reset_dbg x%0d: got %h expected %h", i, dbg_data, exp); end
        end
        n_cmp++; if (wr_count !== 32'd0) begin n_err++; $display("FAIL reset_count: got %h expected %h", wr_count, 32'd0); end
    endtask

    task automatic test_basic_write();
        @(negedge clk);
        wb_en_wb = 1'b1; rd_addr_wb = 5'd5; rd_data_wb = 32'hDEADBEEF;
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'd1);
        @(negedge clk);
        wb_en_wb = 1'b0;
        rs1_addr_id = 5'd5; rs2_addr_id = 5'd5; dbg_addr = 5'd5;
        #1;
        exp = exp_q.pop_front();
        n_cmp++; if (rs1_data_id !== exp) begin n_err++; $display("FAIL basic_rs1: got %h expected %h", rs1_data_id, exp); end
        exp = exp_q.pop_front();
        n_cmp++; if (rs2_data_id !== exp) begin n_err++; $display("FAIL basic_rs2: got %h expected %h", rs2_data_id, exp); end
        exp = exp_q.pop_front();
        n_cmp++; if (dbg_data !== exp) begin n_err++; $display("FAIL basic_dbg: got %h expected %h", dbg_data, exp); end
        exp = exp_q.pop_front();
        n_cmp++; if (wr_count !== exp) begin n_err++; $display("FAIL basic_count: got %h expected %h", wr_count, exp); end
    endtask

    task automatic test_x0_protect();
        @(negedge clk);
        wb_en_wb = 1'b1; rd_addr_wb = 5'd0; rd_data_wb = 32'h12345678;
        rs1_addr_id = 5'd0;
        exp_q.push_back(32'h0);
        #1;
        exp = exp_q.pop_front();
        n_cmp++; if (rs1_data_id !== exp) begin n_err++; $display("FAIL x0_write_cycle: got %h expected %h", rs1_data_id, exp); end
        @(negedge clk);
        wb_en_wb = 1'b0;
        rs2_addr_id = 5'd0; dbg_addr = 5'd0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'd1);
        #1;
        exp = exp_q.pop_front();
        n_cmp++; if (rs1_data_id !== exp) begin n_err++; $display("FAIL x0_after_rs1: got %h expected %h", rs1_data_id, exp); end
        exp = exp_q.pop_front();
        n_cmp++; if (rs2_data_id !== exp) begin n_err++; $display("FAIL x0_after_rs2: got %h expected %h", rs2_data_id, exp); end
        exp = exp_q.pop_front();
        n_cmp++; if (dbg_data !== exp) begin n_err++; $display("FAIL x0_after_dbg: got %h expected %h", dbg_data, exp); end
        exp = exp_q.pop_front();
        n_cmp++; if (wr_count !== exp) begin n_err++; $display("FAIL x0_count: got %h expected %h", wr_count, exp); end
    endtask

    task automatic test_raw_x7();
        @(negedge clk);
        wb_en_wb = 1'b1; rd_addr_wb = 5'd7; rd_data_wb = 32'h11;
        @(negedge clk);
        rd_data_wb = 32'h22;
        rs1_addr_id = 5'd7; rs2_addr_id = 5'd7; dbg_addr = 5'd7;
        exp_q.push_back(BYPASS ? 32'h22 : 32'h11);
        exp_q.push_back(BYPASS ? 32'h22 : 32'h11);
        exp_q.push_back(32'h11);
        #1;
        exp = exp_q.pop_front();
        n_cmp++; if (rs1_data_id !== exp) begin n_err++; $display("FAIL raw_rs1_write_cycle: got %h expected %h", rs1_data_id, exp); end
        exp = exp_q.pop_front();
        n_cmp++; if (rs2_data_id !== exp) begin n_err++; $display("FAIL raw_rs2_write_cycle: got %h expected %h", rs2_data_id, exp); end
        exp = exp_q.pop_front();
        n_cmp++; if (dbg_data !== exp) begin n_err++; $display("FAIL raw_dbg_write_cycle: got %h expected %h", dbg_data, exp); end
        @(negedge clk);
        wb_en_wb = 1'b0;
        exp_q.push_back(32'h22);
        exp_q.push_back(32'h22);
        exp_q.push_back(32'd3);
        #1;
        exp = exp_q.pop_front();
        n_cmp++; if (rs1_data_id !== exp) begin n_err++; $display("FAIL raw_rs1_next: got %h expected %h", rs1_data_id, exp); end
        exp = exp_q.pop_front();
        n_cmp++; if (dbg_data !== exp) begin n_err++; $display("FAIL raw_dbg_next: got %h expected %h", dbg_data, exp); end
        exp = exp_q.pop_front();
        n_cmp++; if (wr_count !== exp) begin n_err++; $display("FAIL raw_count: got %h expected %h", wr_count, exp); end
    endtask

    task automatic test_reset_collision();
        @(negedge clk);
        wb_en_wb = 1'b1; rd_addr_wb = 5'd3; rd_data_wb = 32'h33;
        @(negedge clk);
        rst = 1'b1; rd_data_wb = 32'hAAAA5555;
        rs1_addr_id = 5'd3;
        exp_q.push_back(32'h33);
        #1;
        exp = exp_q.pop_front();
        n_cmp++; if (rs1_data_id !== exp) begin n_err++; $display("FAIL bypass_during_rst: got %h expected %h", rs1_data_id, exp); end
        @(negedge clk);
        rst = 1'b0; wb_en_wb = 1'b0;
        rs2_addr_id = 5'd5; dbg_addr = 5'd3;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'd0);
        #1;
        exp = exp_q.pop_front();
        n_cmp++; if (rs1_data_id !== exp) begin n_err++; $display("FAIL collide_x3: got %h expected %h", rs1_data_id, exp); end
        exp = exp_q.pop_front();
        n_cmp++; if (rs2_data_id !== exp) begin n_err++; $display("FAIL collide_x5_cleared: got %h expected %h", rs2_data_id, exp); end
        exp = exp_q.pop_front();
        n_cmp++; if (dbg_data !== exp) begin n_err++; $display("FAIL collide_dbg_x3: got %h expected %h", dbg_data, exp); end
        exp = exp_q.pop_front();
        n_cmp++; if (wr_count !== exp) begin n_err++; $display("FAIL collide_count: got %h expected %h", wr_count, exp); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e1, e2;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        cnt_model = 32'd0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            wb_en_wb    = 1'($urandom_range(0, 1));
            rd_addr_wb  = 5'($urandom_range(0, 31));
            rd_data_wb  = $urandom;
            rs1_addr_id = ($urandom_range(0, 2) == 0) ? rd_addr_wb : 5'($urandom_range(0, 31));
            rs2_addr_id = ($urandom_range(0, 2) == 0) ? rd_addr_wb : 5'($urandom_range(0, 31));
            dbg_addr    = ($urandom_range(0, 2) == 0) ? rd_addr_wb : 5'($urandom_range(0, 31));
            e1 = (rs1_addr_id == 5'd0) ? 32'h0 :
                 (BYPASS && wb_en_wb && rd_addr_wb != 5'd0 && rd_addr_wb == rs1_addr_id) ? rd_data_wb : model[rs1_addr_id];
            e2 = (rs2_addr_id == 5'd0) ? 32'h0 :
                 (BYPASS && wb_en_wb && rd_addr_wb != 5'd0 && rd_addr_wb == rs2_addr_id) ? rd_data_wb : model[rs2_addr_id];
            exp_q.push_back(e1);
            exp_q.push_back(e2);
            exp_q.push_back((dbg_addr == 5'd0) ? 32'h0 : model[dbg_addr]);
            exp_q.push_back(cnt_model);
            #1;
            exp = exp_q.pop_front();
            n_cmp++; if (rs1_data_id !== exp) begin n_err++; $display("FAIL b2b_rs1 cyc%0d: got %h expected %h", cyc, rs1_data_id, exp); end
            exp = exp_q.pop_front();
            n_cmp++; if (rs2_data_id !== exp) begin n_err++; $display("FAIL b2b_rs2 cyc%0d: got %h expected %h", cyc, rs2_data_id, exp); end
            exp = exp_q.pop_front();
            n_cmp++; if (dbg_data !== exp) begin n_err++; $display("FAIL b2b_dbg cyc%0d: got %h expected %h", cyc, dbg_data, exp); end
            exp = exp_q.pop_front();
            n_cmp++; if (wr_count !== exp) begin n_err++; $display("FAIL b2b_count cyc%0d: got %h expected %h", cyc, wr_count, exp); end
            if (wb_en_wb && rd_addr_wb != 5'd0) begin
                model[rd_addr_wb] = rd_data_wb;
                cnt_model = cnt_model + 32'd1;
            end
        end
        @(negedge clk);
        wb_en_wb = 1'b0;
    endtask

    task automatic test_count_wrap();
        @(negedge clk);
        wb_en_wb = 1'b0;
        force dut.wr_count_q = 32'hFFFFFFFF;
        #1;
        release dut.wr_count_q;
        exp_q.push_back(32'hFFFFFFFF);
        #1;
        exp = exp_q.pop_front();
        n_cmp++; if (wr_count !== exp) begin n_err++; $display("FAIL wrap_preload: got %h expected %h", wr_count, exp); end
        wb_en_wb = 1'b1; rd_addr_wb = 5'd9; rd_data_wb = 32'h99990009;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'h99990009);
        @(negedge clk);
        wb_en_wb = 1'b0;
        rs1_addr_id = 5'd9;
        #1;
        exp = exp_q.pop_front();
        n_cmp++; if (wr_count !== exp) begin n_err++; $display("FAIL wrap_count: got %h expected %h", wr_count, exp); end
        exp = exp_q.pop_front();
        n_cmp++; if (rs1_data_id !== exp) begin n_err++; $display("FAIL wrap_x9: got %h expected %h", rs1_data_id, exp); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        wb_en_wb = 1'b0; rd_addr_wb = '0; rd_data_wb = '0;
        rs1_addr_id = '0; rs2_addr_id = '0; dbg_addr = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_basic_write();
        test_x0_protect();
        test_raw_x7();
        test_reset_collision();
        test_back_to_back();
        test_count_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
